// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory request/response bus: the LSU drives it as master, the memory answers as slave.
interface lsu_mem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [63:0] req_addr;
   logic        req_wen;
   logic [63:0] req_wdata;
   logic [7:0]  req_wstrb;
   logic        resp_valid;
   logic [63:0] resp_rdata;

   modport master (
      output req_valid, req_addr, req_wen, req_wdata, req_wstrb,
      input  req_ready, resp_valid, resp_rdata
   );
   modport slave (
      input  req_valid, req_addr, req_wen, req_wdata, req_wstrb,
      output req_ready, resp_valid, resp_rdata
   );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// EX-stage load/store unit: one memory access per instruction over a valid/ready bus, with stall and timeout.
// Define LSU_MISALIGN_EN to reject naturally-misaligned accesses (o_lsu_misalign) instead of aligning them down.
module lsu_mem_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 1023
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_ex_valid,
   input  logic           i_ex_mem_ena,
   input  logic           i_ex_mem_wen,
   input  logic [3:0]     i_ex_mem_mask,
   input  logic [63:0]    i_ex_addr,
   input  logic [63:0]    i_ex_wdata,
   output logic           o_mem_stall,
   output logic           o_lsu_done,
   output logic [63:0]    o_lsu_rdata,
   output logic           o_lsu_timeout,
`ifdef LSU_MISALIGN_EN
   output logic           o_lsu_misalign,
`endif
   lsu_mem_ctrl_if.master dmem
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP, ST_DONE} state_t;

   localparam logic [9:0] LP_CNT_LAST = 10'(TIMEOUT_CYC - 1);

   state_t      r_state, w_state_nxt;
   logic [9:0]  r_cnt;
   logic [63:0] r_rdata;
   logic        r_timeout;
   logic [63:0] r_req_addr;
   logic        r_req_wen;
   logic [63:0] r_req_wdata;
   logic [7:0]  r_req_wstrb;
   logic [2:0]  r_off;
   logic [1:0]  r_size;
   logic        r_zext;

   logic        w_start;
   logic        w_cnt_hit;
   logic [7:0]  w_size_strb;
   logic [2:0]  w_align_mask;
   logic [2:0]  w_off;
   logic [63:0] w_shifted;
   logic [63:0] w_load;
   logic        w_unused_mask3;

   assign w_start        = i_ex_valid & i_ex_mem_ena;
   assign w_cnt_hit      = (r_cnt == LP_CNT_LAST);
   assign w_unused_mask3 = i_ex_mem_mask[3];

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_size_strb  = 8'h01;
      w_align_mask = 3'b000;
      case (i_ex_mem_mask[1:0])
         2'd0:    begin w_size_strb = 8'h01; w_align_mask = 3'b000; end
         2'd1:    begin w_size_strb = 8'h03; w_align_mask = 3'b001; end
         2'd2:    begin w_size_strb = 8'h0F; w_align_mask = 3'b011; end
         default: begin w_size_strb = 8'hFF; w_align_mask = 3'b111; end
      endcase
   end

   // Offset bits below the access size are dropped, so every issued access is naturally aligned.
   assign w_off = i_ex_addr[2:0] & ~w_align_mask;

`ifdef LSU_MISALIGN_EN
   logic w_misalign;
   logic r_misalign;
   assign w_misalign     = |(i_ex_addr[2:0] & w_align_mask);
   assign o_lsu_misalign = (r_state == ST_DONE) & r_misalign;
`endif

   always_comb begin
      w_shifted = dmem.resp_rdata >> {r_off, 3'b000};
      w_load    = '0;
      case (r_size)
         2'd0:    w_load = r_zext ? {56'd0, w_shifted[7:0]}  : {{56{w_shifted[7]}},  w_shifted[7:0]};
         2'd1:    w_load = r_zext ? {48'd0, w_shifted[15:0]} : {{48{w_shifted[15]}}, w_shifted[15:0]};
         2'd2:    w_load = r_zext ? {32'd0, w_shifted[31:0]} : {{32{w_shifted[31]}}, w_shifted[31:0]};
         default: w_load = w_shifted;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
`ifdef LSU_MISALIGN_EN
               w_state_nxt = w_misalign ? ST_DONE : ST_REQ;
`else
               w_state_nxt = ST_REQ;
`endif
            end
         end
         ST_REQ:  if (dmem.req_ready) w_state_nxt = ST_RESP;
         ST_RESP: if (dmem.resp_valid || w_cnt_hit) w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_IDLE;
      endcase
      // Releasing the stall in DONE is what lets the ID/EX register advance.
      o_mem_stall    = w_start & (r_state != ST_DONE);
      o_lsu_done     = (r_state == ST_DONE);
      o_lsu_timeout  = (r_state == ST_DONE) & r_timeout;
      dmem.req_valid = (r_state == ST_REQ);
   end

   assign dmem.req_addr  = r_req_addr;
   assign dmem.req_wen   = r_req_wen;
   assign dmem.req_wdata = r_req_wdata;
   assign dmem.req_wstrb = r_req_wstrb;
   assign o_lsu_rdata    = r_rdata;

   // NOTE: the captured request fields are reset too; they are few flops and keep the bus free of X after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_rdata     <= '0;
         r_timeout   <= 1'b0;
         r_req_addr  <= '0;
         r_req_wen   <= 1'b0;
         r_req_wdata <= '0;
         r_req_wstrb <= '0;
         r_off       <= '0;
         r_size      <= '0;
         r_zext      <= 1'b0;
`ifdef LSU_MISALIGN_EN
         r_misalign  <= 1'b0;
`endif
      end else begin
         r_cnt <= (r_state == ST_RESP) ? r_cnt + 10'd1 : '0;
         if (r_state == ST_IDLE && w_start) begin
            r_req_addr  <= {i_ex_addr[63:3], 3'b000};
            r_req_wen   <= i_ex_mem_wen;
            r_req_wdata <= i_ex_wdata << {w_off, 3'b000};
            r_req_wstrb <= i_ex_mem_wen ? (w_size_strb << w_off) : 8'h00;
            r_off       <= w_off;
            r_size      <= i_ex_mem_mask[1:0];
            r_zext      <= i_ex_mem_mask[2];
            r_rdata     <= '0;
            r_timeout   <= 1'b0;
`ifdef LSU_MISALIGN_EN
            r_misalign  <= w_misalign;
`endif
         end else if (r_state == ST_RESP) begin
            if (dmem.resp_valid) begin
               r_rdata <= r_req_wen ? '0 : w_load;
            end else if (w_cnt_hit) begin
               r_rdata   <= '0;
               r_timeout <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: randomized accesses against a byte-level reference model.
module tb_lsu_mem_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_mem_ena, ex_mem_wen;
   logic [3:0]  ex_mem_mask;
   logic [63:0] ex_addr, ex_wdata;
   logic        mem_stall, lsu_done, lsu_timeout;
   logic [63:0] lsu_rdata;
`ifdef LSU_MISALIGN_EN
   logic        lsu_misalign;
`endif

   always #5 clk = ~clk;

   lsu_mem_ctrl_if dmem ();

   lsu_mem_ctrl #(.TIMEOUT_CYC(TO)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_ex_valid     (ex_valid),
      .i_ex_mem_ena   (ex_mem_ena),
      .i_ex_mem_wen   (ex_mem_wen),
      .i_ex_mem_mask  (ex_mem_mask),
      .i_ex_addr      (ex_addr),
      .i_ex_wdata     (ex_wdata),
      .o_mem_stall    (mem_stall),
      .o_lsu_done     (lsu_done),
      .o_lsu_rdata    (lsu_rdata),
      .o_lsu_timeout  (lsu_timeout),
`ifdef LSU_MISALIGN_EN
      .o_lsu_misalign (lsu_misalign),
`endif
      .dmem           (dmem.master)
   );

   typedef struct {
      logic [63:0] rdata;
      logic        timeout;
      logic        misalign;
   } rsp_t;

   typedef struct {
      logic [63:0] addr;
      logic        wen;
      logic [63:0] wdata;
      logic [7:0]  wstrb;
   } req_t;

   rsp_t rsp_q[$];
   req_t req_q[$];
   rsp_t mon_rsp;
   req_t mon_req;
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: pick the bytes of the access out of the 8-byte word, then extend.
   function automatic logic [63:0] model_load(logic [63:0] raw, logic [63:0] addr, logic [3:0] mask);
      int          nb;
      int          off;
      logic [63:0] v;
      logic [63:0] keep;
      nb  = 1 << mask[1:0];
      off = (int'(addr % 64'd8) / nb) * nb;
      v   = raw >> (8 * off);
      if (nb < 8) begin
         keep = (64'd1 << (8 * nb)) - 64'd1;
         v    = v & keep;
         if (!mask[2] && v[8 * nb - 1]) v = v | ~keep;
      end
      return v;
   endfunction

   // Scoreboard monitor: checks every accepted request and every completion.
   always @(negedge clk) begin
      if (rst_n) begin
         if (dmem.req_valid && dmem.req_ready) begin
            if (req_q.size() == 0) begin
               check("req_unexpected", 1, 0);
            end else begin
               mon_req = req_q.pop_front();
               check("req_addr",  dmem.req_addr,  mon_req.addr);
               check("req_wen",   dmem.req_wen,   mon_req.wen);
               check("req_wdata", dmem.req_wdata, mon_req.wdata);
               check("req_wstrb", dmem.req_wstrb, mon_req.wstrb);
            end
         end
         if (lsu_done) begin
            if (rsp_q.size() == 0) begin
               check("done_unexpected", 1, 0);
            end else begin
               mon_rsp = rsp_q.pop_front();
               check("lsu_rdata",   lsu_rdata,   mon_rsp.rdata);
               check("lsu_timeout", lsu_timeout, mon_rsp.timeout);
`ifdef LSU_MISALIGN_EN
               check("lsu_misalign", lsu_misalign, mon_rsp.misalign);
`endif
            end
         end
      end
   end

   // One EX instruction. rdly: cycles ready is held low; sdly: response delay in RESP, -1 = never.
   task automatic do_access(input bit v, input bit ena, input bit wen, input logic [3:0] mask,
                            input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] raw,
                            input int rdly, input int sdly);
      int   nb, off, exp_lat, lat, acc_cyc, stall_bad, stab_bad;
      bit   mis, accepted, done, seen;
      req_t first, e_req;
      rsp_t e_rsp;
      logic [15:0] strb;
      nb = 1 << mask[1:0];
      off = (int'(addr % 64'd8) / nb) * nb;
      accepted = 0; done = 0; seen = 0; stall_bad = 0; stab_bad = 0; lat = -1; acc_cyc = 0;
`ifdef LSU_MISALIGN_EN
      mis = (addr % 64'(nb)) != 64'd0;
`else
      mis = 0;
`endif
      @(posedge clk); #1;
      ex_valid = v; ex_mem_ena = ena; ex_mem_wen = wen; ex_mem_mask = mask;
      ex_addr = addr; ex_wdata = wdata;
      dmem.req_ready  = (rdly == 0);
      dmem.resp_valid = 1'b0;
      if (!(v && ena)) begin
         repeat (3) begin
            @(negedge clk);
            if (mem_stall !== 1'b0 || dmem.req_valid !== 1'b0 || lsu_done !== 1'b0) stall_bad++;
         end
         check("idle_quiet", stall_bad, 0);
         return;
      end
      if (mis) begin
         e_rsp = '{rdata: '0, timeout: 1'b0, misalign: 1'b1};
         exp_lat = 1;
      end else begin
         strb  = ((16'd1 << nb) - 16'd1) << off;
         e_req = '{addr: {addr[63:3], 3'b000}, wen: wen, wdata: wdata << (8 * off),
                   wstrb: wen ? strb[7:0] : 8'h00};
         req_q.push_back(e_req);
         if (sdly < 0) begin
            e_rsp   = '{rdata: '0, timeout: 1'b1, misalign: 1'b0};
            exp_lat = rdly + 2 + TO;
         end else begin
            e_rsp   = '{rdata: wen ? 64'd0 : model_load(raw, addr, mask), timeout: 1'b0, misalign: 1'b0};
            exp_lat = rdly + sdly + 3;
         end
      end
      rsp_q.push_back(e_rsp);
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (lsu_done) begin
            done = 1; lat = c;
            if (mem_stall !== 1'b0) stall_bad++;
         end else if (mem_stall !== 1'b1) begin
            stall_bad++;
         end
         if (!accepted) begin
            if (dmem.req_valid) begin
               if (!seen) begin
                  first = '{addr: dmem.req_addr, wen: dmem.req_wen, wdata: dmem.req_wdata, wstrb: dmem.req_wstrb};
                  seen  = 1;
               end else if (dmem.req_addr !== first.addr || dmem.req_wen !== first.wen ||
                            dmem.req_wdata !== first.wdata || dmem.req_wstrb !== first.wstrb) begin
                  stab_bad++;
               end
               if (dmem.req_ready) begin accepted = 1; acc_cyc = c; end
            end else if (seen) begin
               stab_bad++;
            end
         end
         if (!done) begin
            @(posedge clk); #1;
            dmem.req_ready  = (c + 1 > rdly);
            dmem.resp_valid = accepted && (sdly >= 0) && (c + 1 == acc_cyc + 1 + sdly);
            dmem.resp_rdata = dmem.resp_valid ? raw : {$urandom, $urandom};
         end
      end
      if (!done) check("done_seen", 0, 1);
      else       check("latency", lat, exp_lat);
      check("stall_profile", stall_bad, 0);
      check("req_stable", stab_bad, 0);
   endtask

   // Reset asserted while waiting in RESP; a late response must be ignored.
   task automatic reset_mid_resp();
      int   junk;
      req_t e_req;
      junk = 0;
      @(posedge clk); #1;
      ex_valid = 1; ex_mem_ena = 1; ex_mem_wen = 0; ex_mem_mask = 4'b0011;
      ex_addr = 64'h0000_0000_9000_0010; ex_wdata = '0;
      dmem.req_ready = 1; dmem.resp_valid = 0;
      e_req = '{addr: 64'h0000_0000_9000_0010, wen: 1'b0, wdata: '0, wstrb: 8'h00};
      req_q.push_back(e_req);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b0;
      ex_valid = 0;
      #1;
      check("rst_req_valid", dmem.req_valid, 0);
      check("rst_done", lsu_done, 0);
      check("rst_rdata", lsu_rdata, 0);
      @(posedge clk); #3 rst_n = 1'b1;
      @(posedge clk); #1;
      dmem.resp_valid = 1; dmem.resp_rdata = 64'hDEAD_BEEF_0123_4567;
      @(posedge clk); #1;
      dmem.resp_valid = 0;
      repeat (4) begin
         @(negedge clk);
         if (lsu_done !== 1'b0 || dmem.req_valid !== 1'b0 || lsu_rdata !== 64'd0) junk++;
      end
      check("rst_late_resp_ignored", junk, 0);
   endtask

   logic [3:0]  r_mask;
   logic [63:0] r_addr, r_wdata, r_raw;
   int          r_rdly, r_sdly;
   bit          r_v, r_ena, r_wen;

   initial begin
      rst_n = 1'b0;
      ex_valid = 0; ex_mem_ena = 0; ex_mem_wen = 0; ex_mem_mask = '0; ex_addr = '0; ex_wdata = '0;
      dmem.req_ready = 0; dmem.resp_valid = 0; dmem.resp_rdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_done", lsu_done, 0);
      check("reset_rdata", lsu_rdata, 0);
      check("reset_timeout", lsu_timeout, 0);
      check("reset_req_valid", dmem.req_valid, 0);
      check("reset_stall", mem_stall, 0);
      rst_n = 1'b1;

      // LB sign-extended, minimum latency.
      do_access(1, 1, 0, 4'b0000, 64'h8000_0003, '0, 64'h0000_0000_80FF_0000, 0, 0);
      check("lb_value", lsu_rdata, 64'hFFFF_FFFF_FFFF_FF80);
      // SH into the top halfword.
      do_access(1, 1, 1, 4'b0001, 64'h8000_0006, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
      check("sh_rdata_zero", lsu_rdata, 0);
      // Ready held low for 5 cycles.
      do_access(1, 1, 0, 4'b0010, 64'h1000_0004, '0, 64'h8765_4321_0000_0000, 5, 1);
      // No response: timeout.
      do_access(1, 1, 0, 4'b0011, 64'h2000_0000, '0, 64'h1, 1, -1);
      check("timeout_rdata", lsu_rdata, 0);
      // Response in the last RESP cycle before timeout.
      do_access(1, 1, 0, 4'b0100, 64'h2000_0001, '0, 64'h0000_0000_0000_F000, 0, TO - 1);
      reset_mid_resp();
      // LW at offset 2.
      do_access(1, 1, 0, 4'b0010, 64'h8000_0002, '0, 64'h1111_2222_8899_AABB, 0, 0);
      // Zero-extending loads and doubleword.
      do_access(1, 1, 0, 4'b0101, 64'h3000_0006, '0, 64'hF00D_0000_0000_0000, 0, 2);
      do_access(1, 1, 0, 4'b0110, 64'h3000_0004, '0, 64'hCAFE_BABE_0000_0000, 2, 0);
      do_access(1, 1, 1, 4'b0011, 64'h3000_0008, 64'h0102_0304_0506_0708, '0, 1, 0);
      // Non-memory and non-valid instructions.
      do_access(1, 0, 0, 4'b0000, 64'h4000_0000, '0, '0, 0, 0);
      do_access(0, 1, 1, 4'b0000, 64'h4000_0000, '0, '0, 0, 0);

      for (int i = 0; i < 60; i++) begin
         r_v     = ($urandom_range(0, 9) != 0);
         r_ena   = ($urandom_range(0, 9) != 0);
         r_wen   = $urandom_range(0, 1) == 1;
         r_mask  = 4'($urandom);
         r_addr  = {$urandom, $urandom};
         r_wdata = {$urandom, $urandom};
         r_raw   = {$urandom, $urandom};
         r_rdly  = $urandom_range(0, 3);
         r_sdly  = $urandom_range(0, 8);
         if (r_sdly == 8) r_sdly = -1;
         else             r_sdly = r_sdly % TO;
         do_access(r_v, r_ena, r_wen, r_mask, r_addr, r_wdata, r_raw, r_rdly, r_sdly);
      end

      @(posedge clk); #1;
      ex_valid = 0;
      repeat (3) @(negedge clk);
      check("sb_rsp_drained", rsp_q.size(), 0);
      check("sb_req_drained", req_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
